// File: rtl/arbiter_rr_param.sv
// -----------------------------------------------------------------------------
// arbiter_rr_param
//
// Purpose:
//   N-requester arbiter with registered, locked grants. A run-time mode input
//   selects fixed priority (bit 0 highest) or round-robin starting at a
//   rotating pointer. Once granted, a requester keeps the resource for as long
//   as its request stays high. In round-robin mode an optional hold limit
//   forces rotation when other requesters are waiting. `grant` is intended to
//   drive the select of the shared-resource mux.
//
// Handshake:
//   Requests are level-sensitive. A requester holds its request bit high to
//   ask for and to keep the resource, and drops it to release. Every decision
//   uses request/mode sampled at a rising edge and appears on the outputs
//   right after that edge. There is no separate ready/valid pair.
//
// Parameters:
//   N         number of requesters (N >= 2)
//   IDW       width of grant_id, $clog2(N)
//   MAX_HOLD  grant cycles before round-robin preemption; 0 disables it
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   request[N]   request vector, bit i = requester i wants the resource
//   mode         0 = fixed priority, 1 = round-robin
//   grant[N]     registered one-hot grant, or all zero
//   grant_id     binary index of the current owner, 0 when idle
//   grant_valid  high whenever any grant bit is set
// -----------------------------------------------------------------------------
module arbiter_rr_param #(
   parameter int N        = 4,
   parameter int IDW      = $clog2(N),
   parameter int MAX_HOLD = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   request,
   input  logic           mode,
   output logic [N-1:0]   grant,
   output logic [IDW-1:0] grant_id,
   output logic           grant_valid
);

   // The hold counter has to reach MAX_HOLD-1; keep at least one bit so the
   // counter exists even when preemption is disabled.
   localparam int HCW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

   // Saturation value of the hold counter. With preemption disabled the
   // counter simply stays at zero.
   localparam logic [HCW-1:0] HOLD_MAX   = (MAX_HOLD > 0) ? HCW'(MAX_HOLD - 1) : '0;
   localparam logic           PREEMPT_EN = (MAX_HOLD != 0);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   state_t         state_q, state_d;
   logic [IDW-1:0] owner_q, owner_d;
   logic [IDW-1:0] ptr_q,   ptr_d;
   logic [HCW-1:0] hold_q,  hold_d;
   logic [N-1:0]   grant_q, grant_d;

   // Result of one arbitration: {found, index}.
   logic [IDW:0]   pick_all;
   logic [IDW:0]   pick_oth;

   // ---------------------------------------------------------------------------
   // arb_pick: first set bit of vec in scan order. In fixed mode the scan starts
   // at index 0; in round-robin mode it starts at `start` and wraps. The loop
   // walks the scan order backwards so that the earliest candidate is the last
   // one written and therefore wins.
   // ---------------------------------------------------------------------------
   function automatic logic [IDW:0] arb_pick(
      input logic [N-1:0]   vec,
      input logic           rr,
      input logic [IDW-1:0] start
   );
      logic [IDW:0]   res;
      logic [IDW-1:0] jj;
      int             base;
      int             j;
      res  = '0;
      base = rr ? int'(start) : 0;
      for (int i = N - 1; i >= 0; i--) begin
         j = base + i;
         if (j >= N) begin
            j = j - N;
         end
         jj = IDW'(j);
         if (vec[jj]) begin
            res = {1'b1, jj};
         end
      end
      return res;
   endfunction

   // Next round-robin start index after granting `w`: (w + 1) mod N.
   function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] w);
      logic [IDW-1:0] r;
      if (int'(w) == N - 1) begin
         r = '0;
      end else begin
         r = w + IDW'(1);
      end
      return r;
   endfunction

   // One-hot expansion of an owner index.
   function automatic logic [N-1:0] to_onehot(input logic [IDW-1:0] idx);
      logic [N-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      hold_d  = hold_q;
      grant_d = grant_q;

      // Full arbitration is used for a fresh grant or a release; the masked
      // one excludes the current owner and is only used for preemption.
      pick_all = arb_pick(request, mode, ptr_q);
      pick_oth = arb_pick(request & ~grant_q, mode, ptr_q);

      case (state_q)
         ST_IDLE: begin
            if (pick_all[IDW]) begin
               state_d = ST_GRANT;
               owner_d = pick_all[IDW-1:0];
               grant_d = to_onehot(pick_all[IDW-1:0]);
               ptr_d   = next_ptr(pick_all[IDW-1:0]);
               hold_d  = '0;
            end
         end

         ST_GRANT: begin
            if (!request[owner_q]) begin
               // Owner released: hand over in the same edge, no idle bubble.
               if (pick_all[IDW]) begin
                  owner_d = pick_all[IDW-1:0];
                  grant_d = to_onehot(pick_all[IDW-1:0]);
                  ptr_d   = next_ptr(pick_all[IDW-1:0]);
                  hold_d  = '0;
               end else begin
                  state_d = ST_IDLE;
                  owner_d = '0;
                  grant_d = '0;
                  hold_d  = '0;
               end
            end else if (mode && PREEMPT_EN && (hold_q == HOLD_MAX) && pick_oth[IDW]) begin
               // Owner has used up its slot and someone else is waiting.
               owner_d = pick_oth[IDW-1:0];
               grant_d = to_onehot(pick_oth[IDW-1:0]);
               ptr_d   = next_ptr(pick_oth[IDW-1:0]);
               hold_d  = '0;
            end else if (hold_q != HOLD_MAX) begin
               hold_d = hold_q + HCW'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
            owner_d = '0;
            grant_d = '0;
            hold_d  = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         owner_q <= '0;
         ptr_q   <= '0;
         hold_q  <= '0;
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         hold_q  <= hold_d;
         grant_q <= grant_d;
      end
   end

   // owner_q is forced to zero whenever the arbiter goes idle, so it doubles
   // as grant_id.
   assign grant       = grant_q;
   assign grant_id    = owner_q;
   assign grant_valid = |grant_q;

endmodule

// File: doc/arbiter_rr_param.md
Name: arbiter_rr_param

Overview:
- Parametrised N-requester arbiter; successor to the 4-input fixed-priority arbiter.
- Adds a run-time selectable mode: fixed-priority or round-robin.
- Grants are registered and locked: the owner keeps its grant while its request stays high.
- Adds an optional hold limit that forces rotation in round-robin mode.
- Sits between N bus masters and a shared resource; `grant` drives the resource mux select.

Parameters:
- N, 4, number of requesters (N >= 2).
- IDW, $clog2(N), width of `grant_id`.
- MAX_HOLD, 4, maximum grant cycles before round-robin preemption; 0 disables preemption.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- request  input  N  request vector; bit i asserted = requester i wants the resource.
- mode  input  1  0 = fixed priority (bit 0 highest), 1 = round-robin.
- grant  output  N  registered one-hot grant, or all zero.
- grant_id  output  IDW  binary index of the current owner; 0 when idle.
- grant_valid  output  1  equals |grant.

Behaviour:
- Reset (rst=1 at an edge): grant=0, grant_id=0, grant_valid=0, ptr=0, hold_cnt=0, state=IDLE. Reset overrides all other events, including mid-grant.
- Latency: decision uses request/mode sampled at edge k; result visible on outputs after edge k (1-cycle registered).
- Internal state: state {IDLE, GRANT}; owner (IDW bits); ptr (IDW bits, round-robin start index); hold_cnt (width to hold MAX_HOLD-1, min 1 bit).
- Arbitration function arb(vec):
  - mode=0: lowest set index of vec.
  - mode=1: first set index scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (wrap modulo N).
  - vec=0: no winner.
- IDLE:
  - request=0: stay IDLE, outputs 0.
  - Otherwise: owner=arb(request), state=GRANT, hold_cnt=0.
- GRANT, evaluated in priority order:
  1. Release: request[owner]=0 → rearbitrate arb(request) in the same edge (zero bubble). No winner → IDLE, grant=0.
  2. Preempt: mode=1, MAX_HOLD!=0, hold_cnt==MAX_HOLD-1, and (request & ~grant)!=0 → owner=arb(request & ~grant), hold_cnt=0.
  3. Otherwise: keep owner; hold_cnt increments, saturating at MAX_HOLD-1.
- Mode 0 never preempts. A higher-priority request arriving does not steal a locked grant.
- ptr update: on every new grant to winner w, ptr = (w+1) mod N. Unchanged while holding or idle. Updated in both modes.
- Mode change: takes effect at the next arbitration only; never disturbs the current owner.
- Invariants: grant is one-hot or zero; grant_id matches grant; no grant is issued to a requester whose request bit was 0 at the deciding edge.
- Requests are level-sensitive and need no handshake beyond holding request high. The requester releases by dropping its bit; grant clears (or moves) after the next edge.

Test Plan (N=4, MAX_HOLD=4):
- Reset: rst=1 for 2 cycles with request=4'hF → grant=0, grant_id=0, grant_valid=0 throughout; after release in mode=1 → first grant=4'b0001.
- Fixed lock/release: mode=0, request=4'b1010 → grant=4'b0010 one edge later.
  - Then request=4'b1011 → grant stays 4'b0010.
  - Then request=4'b1001 → next edge grant=4'b0001.
- Round-robin rotation: mode=1, request=4'hF held 20 cycles → grant sequence 0001×4, 0010×4, 0100×4, 1000×4, 0001 (wrap).
- Sole requester: mode=1, request=4'b0100 held 10 cycles → grant=4'b0100 continuously, no gaps; then request=0 → grant=0, grant_valid=0 next edge.
- Zero-bubble handover: mode=1, owner=0001, request goes 4'b0001→4'b1100 in one cycle → next edge grant=4'b0100 (ptr=1 scan), grant_valid never drops.
- Reset mid-grant and mode switch:
  - rst pulsed while grant=4'b1000 → grant=0 next edge, ptr=0.
  - mode toggled 0→1 while holding → owner unchanged until release or preemption.
- Sweep: all 16 request values applied for 1 cycle each (as in prior bench) in both modes → one-hot/zero invariant and grant_id consistency checked every cycle.
